// File: rtl/exec_pkg.sv
// Shared types for the execution-engine subunit dispatcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_pkg;

  localparam int EXEC_MODE_W = 3;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_FAIL    = 2'd1,
    RSP_TIMEOUT = 2'd2,
    RSP_BADCH   = 2'd3
  } rsp_status_t;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_ISSUE  = 2'd1,
    CH_WAIT   = 2'd2,
    CH_REPORT = 2'd3
  } chan_state_t;

endpackage

// File: rtl/exec_dispatch_chan.sv
// One subunit channel: IDLE->ISSUE->WAIT->REPORT FSM, mode latch, optional WAIT timeout (EXEC_DISPATCH_TIMEOUT_EN).
// Latency: start -> enable next cycle; done/fail in WAIT -> req same cycle, REPORT next cycle.
// Backpressure: holds REPORT (and its status) until grant; start must only be raised while idle.
module exec_dispatch_chan
  import exec_pkg::*;
#(
  parameter int MODE_W = EXEC_MODE_W
`ifdef EXEC_DISPATCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] start_mode,
  input  logic              done,
  input  logic              fail,
  input  logic              grant,
  output logic              enable,
  output logic [MODE_W-1:0] mode,
  output logic              busy,
  output logic              req,
  output rsp_status_t       req_status,
  output logic              abort
);

  chan_state_t state;
  rsp_status_t stat_q;
  logic        expire;
  logic        finish;

`ifdef EXEC_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             abort_q;

  // WAIT-cycle counter; zeroed during ISSUE so it starts at 0 on WAIT entry
  always_ff @(posedge clk) begin
    if (!rst)                   cnt <= '0;
    else if (state == CH_ISSUE) cnt <= '0;
    else if (state == CH_WAIT)  cnt <= cnt + 1'b1;
  end

  // Expiry only counts when the subunit stays silent on the final cycle
  assign expire = (state == CH_WAIT) && (cnt == CNT_W'(TIMEOUT_CYC - 1)) && !done && !fail;

  // One-cycle abort pulse, coincident with REPORT entry
  always_ff @(posedge clk) begin
    if (!rst) abort_q <= 1'b0;
    else      abort_q <= expire;
  end
  assign abort = abort_q;
`else
  assign expire = 1'b0;
  assign abort  = 1'b0;
`endif

  // Request is raised on the finishing WAIT cycle so the response register can load without a bubble
  always_comb begin
    finish = (state == CH_WAIT) && (done || fail || expire);
    req    = (state == CH_REPORT) || finish;
    busy   = (state != CH_IDLE);
    if (state == CH_REPORT) req_status = stat_q;
    else if (fail)          req_status = RSP_FAIL;
    else if (done)          req_status = RSP_OK;
    else                    req_status = RSP_TIMEOUT;
  end

  // Channel FSM with registered enable pulse and mode latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= CH_IDLE;
      stat_q <= RSP_OK;
      mode   <= '0;
      enable <= 1'b0;
    end else begin
      enable <= 1'b0;
      case (state)
        CH_IDLE: if (start) begin
          mode   <= start_mode;
          enable <= 1'b1;
          state  <= CH_ISSUE;
        end
        CH_ISSUE: state <= CH_WAIT;
        CH_WAIT: if (finish) begin
          stat_q <= req_status;
          state  <= CH_REPORT;
        end
        CH_REPORT: if (grant) state <= CH_IDLE;
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/exec_subunit_dispatch.sv
// N-channel start/complete dispatcher: cmd decode, BADCH flag, round-robin response arbiter; timeout via EXEC_DISPATCH_TIMEOUT_EN.
// Latency: cmd at T -> unit_enable T+1; done at D -> rsp_valid D+1 when uncontended.
// Backpressure: cmd_ready drops for a busy target or pending BADCH; rsp held stable while rsp_ready is low.
module exec_subunit_dispatch
  import exec_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 4,
  parameter int MODE_W      = EXEC_MODE_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CH_W-1:0]          cmd_ch,
  input  logic [MODE_W-1:0]        cmd_mode,
  output logic [NUM_CH-1:0]        unit_enable,
  output logic [NUM_CH*MODE_W-1:0] unit_mode,
  input  logic [NUM_CH-1:0]        unit_done,
  input  logic [NUM_CH-1:0]        unit_fail,
  output logic [NUM_CH-1:0]        unit_abort,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CH_W-1:0]          rsp_ch,
  output logic [1:0]               rsp_status
);

  localparam int NPAD = 1 << CH_W;

  if (NUM_CH < 1 || NUM_CH > 16 || NPAD < NUM_CH || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("exec_subunit_dispatch: invalid parameter set");
  end

  logic [NPAD-1:0]   busy_pad;
  logic              bad_cmd, accept;
  logic              badch_flag, badch_elig;
  logic [CH_W-1:0]   badch_ch, ptr, eff_ptr, rsp_nxt;
  rsp_status_t       rsp_stat_q, pick_stat;
  rsp_status_t       req_stat [NUM_CH];
  logic [NUM_CH-1:0] start_v, grant_v, req_v, is_rsp, elig;
  logic              pick_vld, hs, hs_ch, load;
  logic [CH_W-1:0]   pick_ch;
  int                d, best_d;

  // Zero-padded busy vector lets cmd_ch index any value, including out-of-range channels
  assign busy_pad   = NPAD'(ch_busy);
  assign bad_cmd    = int'(cmd_ch) >= NUM_CH;
  assign cmd_ready  = !busy_pad[cmd_ch] && !badch_flag;
  assign accept     = cmd_valid && cmd_ready;
  assign rsp_status = rsp_stat_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign start_v[i] = accept && !bad_cmd && (int'(cmd_ch) == i);
    assign is_rsp[i]  = rsp_valid && (rsp_stat_q != RSP_BADCH) && (int'(rsp_ch) == i);
    assign grant_v[i] = is_rsp[i] && rsp_ready;

    exec_dispatch_chan #(
      .MODE_W(MODE_W)
`ifdef EXEC_DISPATCH_TIMEOUT_EN
      , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .start      (start_v[i]),
      .start_mode (cmd_mode),
      .done       (unit_done[i]),
      .fail       (unit_fail[i]),
      .grant      (grant_v[i]),
      .enable     (unit_enable[i]),
      .mode       (unit_mode[i*MODE_W +: MODE_W]),
      .busy       (ch_busy[i]),
      .req        (req_v[i]),
      .req_status (req_stat[i]),
      .abort      (unit_abort[i])
    );
  end

  // Round-robin pick; the channel already sitting in the response register is excluded,
  // and a same-cycle handshake advances the search start so the next load is already fair
  always_comb begin
    hs         = rsp_valid && rsp_ready;
    hs_ch      = hs && (rsp_stat_q != RSP_BADCH);
    load       = !rsp_valid || rsp_ready;
    rsp_nxt    = (int'(rsp_ch) == NUM_CH - 1) ? '0 : rsp_ch + 1'b1;
    eff_ptr    = hs_ch ? rsp_nxt : ptr;
    badch_elig = badch_flag && !(rsp_valid && rsp_stat_q == RSP_BADCH);
    elig       = req_v & ~is_rsp;
    pick_vld   = |elig;
    pick_ch    = '0;
    pick_stat  = RSP_OK;
    best_d     = NUM_CH;
    d          = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      d = i - int'(eff_ptr);
      if (d < 0) d = d + NUM_CH;
      if (elig[i] && d < best_d) begin
        best_d    = d;
        pick_ch   = CH_W'(i);
        pick_stat = req_stat[i];
      end
    end
  end

  // Response register, RR pointer and BADCH flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid  <= 1'b0;
      rsp_ch     <= '0;
      rsp_stat_q <= RSP_OK;
      ptr        <= '0;
      badch_flag <= 1'b0;
      badch_ch   <= '0;
    end else begin
      if (load) begin
        if (badch_elig) begin
          rsp_valid  <= 1'b1;
          rsp_ch     <= badch_ch;
          rsp_stat_q <= RSP_BADCH;
        end else if (pick_vld) begin
          rsp_valid  <= 1'b1;
          rsp_ch     <= pick_ch;
          rsp_stat_q <= pick_stat;
        end else begin
          rsp_valid  <= 1'b0;
        end
      end
      if (hs_ch) ptr <= rsp_nxt;
      if (accept && bad_cmd) begin
        badch_flag <= 1'b1;
        badch_ch   <= cmd_ch;
      end else if (hs && rsp_stat_q == RSP_BADCH) begin
        badch_flag <= 1'b0;
      end
    end
  end

endmodule
